// File: rtl/procyon_debug_ctrl_if.sv
// Core-facing retire/redirect stream and the run/halt feedback to the core.
interface procyon_debug_ctrl_if #(
  parameter int OPTN_DATA_WIDTH       = 32,
  parameter int OPTN_ADDR_WIDTH       = 32,
  parameter int OPTN_REGMAP_IDX_WIDTH = 5
);
  logic                             i_retire_en;
  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_retire_rdest;
  logic [OPTN_DATA_WIDTH-1:0]       i_retire_data;
  logic                             i_redirect;
  logic [OPTN_ADDR_WIDTH-1:0]       i_redirect_addr;
  logic                             o_core_en;
  logic                             o_halted;

  modport master (
    output i_retire_en, i_retire_rdest, i_retire_data, i_redirect, i_redirect_addr,
    input  o_core_en, o_halted
  );

  modport slave (
    input  i_retire_en, i_retire_rdest, i_retire_data, i_redirect, i_redirect_addr,
    output o_core_en, o_halted
  );
endinterface

// File: rtl/procyon_debug_ctrl.sv
// Debug controller: run/halt stepping, retire trace ring buffer and redirect stats.
module procyon_debug_ctrl #(
  parameter  int OPTN_DATA_WIDTH       = 32,
  parameter  int OPTN_ADDR_WIDTH       = 32,
  parameter  int OPTN_REGMAP_IDX_WIDTH = 5,
  parameter  int OPTN_TRACE_DEPTH      = 8,
  parameter  int OPTN_STEP_WIDTH       = 8,
  localparam int PW                    = $clog2(OPTN_TRACE_DEPTH)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [1:0]                       i_mode,
  input  logic [OPTN_STEP_WIDTH-1:0]       i_step_count,
  input  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_break_rdest,
  input  logic                             i_resume,
  input  logic [PW-1:0]                    i_trace_sel,
  procyon_debug_ctrl_if.slave              core,
  output logic                             o_trace_valid,
  output logic [OPTN_REGMAP_IDX_WIDTH-1:0] o_trace_rdest,
  output logic [OPTN_DATA_WIDTH-1:0]       o_trace_data,
  output logic [PW:0]                      o_trace_count,
  output logic [15:0]                      o_redirect_cnt,
  output logic [OPTN_ADDR_WIDTH-1:0]       o_redirect_last
);
  localparam int RW = OPTN_REGMAP_IDX_WIDTH;
  localparam int DW = OPTN_DATA_WIDTH;
  localparam int SW = OPTN_STEP_WIDTH;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     step_cnt, step_init;
  logic [PW-1:0]     wr_ptr, rd_idx;
  logic              retire, redirect, halt_cond;
  logic [RW+DW-1:0]  trace_mem [OPTN_TRACE_DEPTH];

  assign core.o_core_en = (state == RUN);
  assign core.o_halted  = (state == HALT);

  // Gating by core_en keeps inputs held by a stalled core from being recorded again.
  assign retire   = core.i_retire_en & core.o_core_en;
  assign redirect = core.i_redirect  & core.o_core_en;

  assign step_init = (i_step_count == '0) ? SW'(1) : i_step_count;

  always_comb begin
    halt_cond = 1'b0;
    case (i_mode)
      2'b00: halt_cond = 1'b0;
      2'b01: halt_cond = 1'b1;
      2'b10: halt_cond = (step_cnt == SW'(1));
      2'b11: halt_cond = (core.i_retire_rdest == i_break_rdest);
      default: halt_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (retire && halt_cond) state_nxt = HALT;
      HALT: if (i_resume)            state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!n_rst)                           step_cnt <= step_init;
    else if (state == HALT && i_resume)   step_cnt <= step_init;
    else if (retire && step_cnt > SW'(1)) step_cnt <= step_cnt - SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr        <= '0;
      o_trace_count <= '0;
    end else if (retire) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (o_trace_count != (PW+1)'(OPTN_TRACE_DEPTH))
        o_trace_count <= o_trace_count + (PW+1)'(1);
    end
  end

  // Trace storage is left uninitialised; trace_count qualifies every read.
  always_ff @(posedge clk) begin
    if (n_rst && retire)
      trace_mem[wr_ptr] <= {core.i_retire_rdest, core.i_retire_data};
  end

  assign rd_idx        = wr_ptr - PW'(1) - i_trace_sel;
  assign o_trace_valid = ({1'b0, i_trace_sel} < o_trace_count);
  assign {o_trace_rdest, o_trace_data} = trace_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_redirect_cnt  <= '0;
      o_redirect_last <= '0;
    end else if (redirect) begin
      o_redirect_last <= core.i_redirect_addr;
      if (o_redirect_cnt != 16'hFFFF) o_redirect_cnt <= o_redirect_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_procyon_debug_ctrl.sv
// Directed bench for procyon_debug_ctrl with hand-computed expectations.
module tb_procyon_debug_ctrl;
  localparam int DW = 32, AW = 32, RW = 5, DEPTH = 8, SW = 8, PW = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [1:0]    mode;
  logic [SW-1:0] step_count;
  logic [RW-1:0] break_rdest;
  logic          resume;
  logic [PW-1:0] trace_sel;
  logic          trace_valid;
  logic [RW-1:0] trace_rdest;
  logic [DW-1:0] trace_data;
  logic [PW:0]   trace_count;
  logic [15:0]   redirect_cnt;
  logic [AW-1:0] redirect_last;

  int n_chk  = 0;
  int n_fail = 0;

  procyon_debug_ctrl_if #(.OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW),
                          .OPTN_REGMAP_IDX_WIDTH(RW)) core_if ();

  procyon_debug_ctrl #(
    .OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW), .OPTN_REGMAP_IDX_WIDTH(RW),
    .OPTN_TRACE_DEPTH(DEPTH), .OPTN_STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_mode(mode), .i_step_count(step_count),
    .i_break_rdest(break_rdest), .i_resume(resume), .i_trace_sel(trace_sel),
    .core(core_if.slave),
    .o_trace_valid(trace_valid), .o_trace_rdest(trace_rdest), .o_trace_data(trace_data),
    .o_trace_count(trace_count), .o_redirect_cnt(redirect_cnt), .o_redirect_last(redirect_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int s);
    trace_sel = PW'(s);
    #1;
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    tick();
    resume = 1'b0;
  endtask

  initial begin
    automatic int rd_seq[4]   = '{1, 2, 5, 7};
    automatic bit halt_exp[4] = '{0, 0, 1, 1};

    n_rst = 1'b0; mode = 2'b00; step_count = '0; break_rdest = '0;
    resume = 1'b0; trace_sel = '0;
    core_if.i_retire_en = 1'b0; core_if.i_retire_rdest = '0; core_if.i_retire_data = '0;
    core_if.i_redirect = 1'b0; core_if.i_redirect_addr = '0;
    tick(); tick();
    n_rst = 1'b1;

    chk("rst_core_en", core_if.o_core_en, 1);
    chk("rst_halted", core_if.o_halted, 0);
    chk("rst_trace_count", trace_count, 0);
    chk("rst_redirect_cnt", redirect_cnt, 0);
    chk("rst_redirect_last", redirect_last, 0);
    chk("rst_trace_valid", trace_valid, 0);

    // single-step: hold retire inputs across the halt
    mode = 2'b01;
    core_if.i_retire_en = 1'b1; core_if.i_retire_rdest = 5'd3; core_if.i_retire_data = 32'hA0;
    tick();
    chk("ss_halted", core_if.o_halted, 1);
    chk("ss_core_en", core_if.o_core_en, 0);
    chk("ss_count1", trace_count, 1);
    tick(); tick();
    chk("ss_held_count", trace_count, 1);
    sel(0); chk("ss_sel0_data", trace_data, 32'hA0);
    sel(1); chk("ss_sel1_valid", trace_valid, 0);
    pulse_resume();
    chk("ss_resumed", core_if.o_halted, 0);
    core_if.i_retire_rdest = 5'd4; core_if.i_retire_data = 32'hA1;
    tick();
    chk("ss_halt2", core_if.o_halted, 1);
    chk("ss_count2", trace_count, 2);
    sel(0); chk("ss2_sel0_data", trace_data, 32'hA1);
    sel(1); chk("ss2_sel1_data", trace_data, 32'hA0);

    // step-N with N=3, then N=0 treated as 1
    core_if.i_retire_en = 1'b0;
    mode = 2'b10; step_count = 8'd3;
    pulse_resume();
    core_if.i_retire_en = 1'b1;
    core_if.i_retire_data = 32'hC1; tick(); chk("sn_r1_halted", core_if.o_halted, 0);
    core_if.i_retire_data = 32'hC2; tick(); chk("sn_r2_halted", core_if.o_halted, 0);
    core_if.i_retire_data = 32'hC3; tick(); chk("sn_r3_halted", core_if.o_halted, 1);
    chk("sn_count", trace_count, 5);
    sel(0); chk("sn_sel0_data", trace_data, 32'hC3);
    step_count = 8'd0;
    pulse_resume();
    core_if.i_retire_data = 32'hC4; tick();
    chk("sn0_halted", core_if.o_halted, 1);
    chk("sn0_count", trace_count, 6);

    // break on rdest 5
    core_if.i_retire_en = 1'b0;
    mode = 2'b11; break_rdest = 5'd5;
    pulse_resume();
    core_if.i_retire_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      core_if.i_retire_rdest = RW'(rd_seq[k]);
      core_if.i_retire_data  = 32'h10 + 32'(rd_seq[k]);
      tick();
      chk($sformatf("brk_halted_%0d", k), core_if.o_halted, 64'(halt_exp[k]));
    end
    chk("brk_count_sat", trace_count, 8);
    sel(0); chk("brk_sel0_rdest", trace_rdest, 5);
    sel(1); chk("brk_sel1_rdest", trace_rdest, 2);
    sel(2); chk("brk_sel2_rdest", trace_rdest, 1);
    chk("brk_sel2_data", trace_data, 32'h11);

    // free-run wrap with data 0..9
    core_if.i_retire_en = 1'b0;
    mode = 2'b00;
    pulse_resume();
    core_if.i_retire_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      core_if.i_retire_rdest = RW'(i);
      core_if.i_retire_data  = 32'(i);
      tick();
      chk($sformatf("fr_core_en_%0d", i), core_if.o_core_en, 1);
    end
    core_if.i_retire_en = 1'b0;
    chk("fr_count", trace_count, 8);
    sel(0); chk("fr_sel0_data", trace_data, 9);
    sel(7); chk("fr_sel7_data", trace_data, 2);
    chk("fr_sel7_valid", trace_valid, 1);

    // retire and redirect together, three times
    for (int k = 0; k < 3; k++) begin
      core_if.i_retire_en = 1'b1; core_if.i_retire_data = 32'h50 + 32'(k);
      core_if.i_redirect  = 1'b1; core_if.i_redirect_addr = AW'(100 * (k + 1));
      tick();
    end
    core_if.i_retire_en = 1'b0; core_if.i_redirect = 1'b0;
    chk("rr_redirect_cnt", redirect_cnt, 3);
    chk("rr_redirect_last", redirect_last, 300);
    sel(0); chk("rr_sel0_data", trace_data, 32'h52);

    // redirect while halted is ignored
    mode = 2'b01;
    core_if.i_retire_en = 1'b1; core_if.i_retire_data = 32'h60;
    tick();
    core_if.i_retire_en = 1'b0;
    chk("hr_halted", core_if.o_halted, 1);
    core_if.i_redirect = 1'b1; core_if.i_redirect_addr = 32'd999;
    tick();
    core_if.i_redirect = 1'b0;
    chk("hr_redirect_cnt", redirect_cnt, 3);
    chk("hr_redirect_last", redirect_last, 300);

    // reset wins over resume while halted
    n_rst = 1'b0; resume = 1'b1;
    tick();
    n_rst = 1'b1; resume = 1'b0;
    chk("r2_core_en", core_if.o_core_en, 1);
    chk("r2_redirect_cnt", redirect_cnt, 0);
    chk("r2_redirect_last", redirect_last, 0);
    chk("r2_trace_count", trace_count, 0);
    for (int s = 0; s < DEPTH; s++) begin
      sel(s);
      chk($sformatf("r2_valid_sel%0d", s), trace_valid, 0);
    end
    tick();
    chk("r2_still_run", core_if.o_core_en, 1);

    // redirect counter saturation
    mode = 2'b00;
    core_if.i_redirect = 1'b1;
    for (int i = 1; i <= 70000; i++) begin
      core_if.i_redirect_addr = AW'(i);
      tick();
      if (i == 65534) chk("sat_fffe", redirect_cnt, 16'hFFFE);
      if (i == 65535) chk("sat_ffff", redirect_cnt, 16'hFFFF);
    end
    core_if.i_redirect = 1'b0;
    tick();
    chk("sat_final_cnt", redirect_cnt, 16'hFFFF);
    chk("sat_final_last", redirect_last, 70000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/procyon_debug_ctrl.md
PROCYON_DEBUG_CTRL -- requirements
Module: procyon_debug_ctrl

Interface
REQ-001 SHALL have parameter OPTN_DATA_WIDTH, default 32: retire data width.
REQ-002 SHALL have parameter OPTN_ADDR_WIDTH, default 32: redirect address width.
REQ-003 SHALL have parameter OPTN_REGMAP_IDX_WIDTH, default 5: destination register index width.
REQ-004 SHALL have parameter OPTN_TRACE_DEPTH, default 8: trace entries; power of 2, at least 2.
REQ-005 SHALL have parameter OPTN_STEP_WIDTH, default 8: step counter width.
REQ-006 SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  core clock.
- n_rst  in  1  synchronous active-low reset.
- i_mode  in  2  halt mode: 00 free-run, 01 single-step, 10 step-N, 11 break-on-rdest.
- i_step_count  in  OPTN_STEP_WIDTH  N for step-N mode.
- i_break_rdest  in  OPTN_REGMAP_IDX_WIDTH  breakpoint register index.
- i_resume  in  1  single-cycle resume pulse, already edge-detected.
- i_retire_en  in  1  core retire valid.
- i_retire_rdest  in  OPTN_REGMAP_IDX_WIDTH  retired register index.
- i_retire_data  in  OPTN_DATA_WIDTH  retired value.
- i_redirect  in  1  core redirect valid.
- i_redirect_addr  in  OPTN_ADDR_WIDTH  redirect target.
- i_trace_sel  in  log2(OPTN_TRACE_DEPTH)  trace entry select; 0 is the newest entry.
- o_core_en  out  1  core clock enable.
- o_halted  out  1  state is HALT.
- o_trace_valid  out  1  the selected entry holds data.
- o_trace_rdest  out  OPTN_REGMAP_IDX_WIDTH  selected entry index.
- o_trace_data  out  OPTN_DATA_WIDTH  selected entry data.
- o_trace_count  out  log2(OPTN_TRACE_DEPTH)+1  number of filled entries.
- o_redirect_cnt  out  16  saturating redirect count.
- o_redirect_last  out  OPTN_ADDR_WIDTH  most recent redirect target.

Function
REQ-007 SHALL implement a two-state FSM, RUN/HALT; o_core_en = (state==RUN), o_halted = (state==HALT), both decoded combinationally from the state register.
REQ-008 SHALL count an event as a retire only when i_retire_en & o_core_en, and as a redirect only when i_redirect & o_core_en; inputs while halted are ignored, so held core outputs are never captured twice.
REQ-009 SHALL define the halt condition on a retire per i_mode, sampled every cycle:
- 00: never.
- 01: any retire.
- 10: retire while step_cnt==1.
- 11: retire with i_retire_rdest==i_break_rdest.
REQ-010 SHALL transition RUN->HALT at the clock edge ending the cycle in which the halt condition holds; the halting retire is captured in the trace on that same edge.
REQ-011 SHALL transition HALT->RUN on i_resume; i_resume in RUN is ignored.
REQ-012 SHALL reload step_cnt from i_step_count on reset and on HALT->RUN, with 0 loaded as 1; SHALL decrement step_cnt on each retire in RUN while step_cnt>1, in every mode.
REQ-013 SHALL write each retire as {rdest,data} to a circular buffer at wr_ptr, then advance wr_ptr modulo OPTN_TRACE_DEPTH; on wrap the oldest entry is overwritten.
REQ-014 SHALL increment o_trace_count per retire, saturating at OPTN_TRACE_DEPTH.
REQ-015 SHALL read the entry at index (wr_ptr-1-i_trace_sel) mod OPTN_TRACE_DEPTH combinationally; o_trace_valid = (i_trace_sel < o_trace_count); rdest and data are don't-care when not valid.
REQ-016 SHALL increment o_redirect_cnt per redirect, saturating at 16'hFFFF, and load o_redirect_last with i_redirect_addr on each redirect.
REQ-017 SHALL treat a retire and a redirect in the same cycle as independent events; both are recorded.
REQ-018 SHALL apply an i_mode change in RUN from the next halt evaluation; step_cnt is not reloaded.

Reset
REQ-019 SHALL set on n_rst low at a clk edge: state RUN, wr_ptr 0, o_trace_count 0, o_redirect_cnt 0, o_redirect_last 0, step_cnt per REQ-012.
REQ-020 SHALL give reset priority over i_resume, retire and redirect in the same cycle; trace RAM contents need not be cleared.

Verification
REQ-021 Mode 01 with retires on 3 consecutive cycles -> halt after the first retire; o_trace_count=1; held retire inputs not re-captured; i_resume -> second retire captured, halt again.
REQ-022 Mode 10 with i_step_count=3 and continuous retires -> halt after exactly the 3rd retire; i_step_count=0 -> halt after the 1st retire.
REQ-023 Mode 11 with i_break_rdest=5 and rdest sequence 1,2,5,7 -> halt after rdest 5; i_trace_sel=0 gives rdest 5; i_trace_sel=2 gives rdest 1.
REQ-024 Mode 00 with DEPTH=8 and 10 retires of data 0..9 -> o_trace_count=8; i_trace_sel=0 gives 9; i_trace_sel=7 gives 2; o_core_en stays 1.
REQ-025 Reset asserted in HALT together with i_resume, and with 3 prior redirects -> next cycle RUN, o_redirect_cnt=0, o_trace_valid=0 for all selects.
REQ-026 70000 redirects -> o_redirect_cnt=16'hFFFF; o_redirect_last = last target address.
